stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- N-input, WIDTH-bit selector with a valid/ready handshake on every channel and one registered output stage.
- Successor to the plain 2:1 combinational bus mux. Adds channel-count generalisation, round-robin or fixed-priority arbitration, backpressure, and a source tag.
- Sits between multiple producers (e.g. ALU/load/immediate paths) and a single consumer register or bus.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- MODE, MUX_RR, arbitration mode from package: MUX_RR (round-robin) or MUX_FIXED (lowest index wins).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected data.
- out_sel  output  $clog2(NUM_IN)  registered index of the source channel of out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset: synchronous, active-high; clk and reset named as elsewhere in the codebase.
  - Reset values: out_valid=0, out_data=0, out_sel=0, RR pointer=0.
  - in_ready is all 0 while reset is high.
- Transfer rule: a transfer occurs on a channel in the cycle where valid and ready are both high at the rising edge.
- accept = ~out_valid | out_ready; the output slot is free or is draining this cycle.
- Grant is one-hot over in_valid:
  - MUX_FIXED: lowest asserted index.
  - MUX_RR: first asserted index searching ptr, ptr+1, ..., wrapping modulo NUM_IN.
- in_ready[i] = grant[i] & accept & ~reset. At most one in_ready bit is high. in_ready never depends on out_valid of another channel.
- On an input transfer from channel g:
  - next cycle out_data = channel g data, out_sel = g, out_valid = 1.
  - Latency is exactly 1 cycle.
- Output drain:
  - out_valid & out_ready with no input transfer: out_valid -> 0, out_data/out_sel hold their last value.
  - Drain and new transfer in the same cycle: the register is overwritten, out_valid stays 1. This gives full throughput, one word per cycle.
- Stall: while out_valid & ~out_ready, out_data and out_sel are stable and in_ready is all 0.
- RR pointer (MUX_RR only):
  - On a transfer from g, ptr <= (g+1) mod NUM_IN; wrap from NUM_IN-1 to 0.
  - No transfer: ptr holds.
  - MUX_FIXED: ptr is constant 0.
- No in_valid asserted: grant = 0, no transfer, ptr holds.
- A producer may drop in_valid without having transferred. Grant is recomputed each cycle, with no lock-in.
- Reset mid-operation: any held output word is discarded and pointer returns to 0. An in_valid high during the reset cycle does not transfer.
- Fairness: in MUX_RR with all NUM_IN inputs valid and out_ready=1, grants cycle 0,1,...,NUM_IN-1,0,...

Decomposition:
- Package mux_pkg:
  - enum mux_mode_t {MUX_RR, MUX_FIXED}.
  - localparam MUX_MAX_IN = 16.
- Sub-module rr_arbiter #(NUM_IN, MODE):
  - Contains the pointer register and the one-hot grant plus index encode.
  - Ports: clk, reset, req, advance, grant, grant_idx.
- The top holds the accept logic, the data select via an indexed part-select, and the output register.

Test Plan:
- Reset with all in_valid=1: while reset high, in_ready=4'b0000, out_valid=0, out_data=0. After release, first grant is channel 0.
- RR fairness: NUM_IN=4, all valid, data ch_i=8'hA0+i, out_ready=1 → out_data sequence A0,A1,A2,A3,A0, out_sel 0,1,2,3,0, one word per cycle.
- Backpressure: ch2 only valid with 8'h5C, out_ready=0 for 3 cycles → out_valid=1, out_data=5C stable, in_ready=0 for those cycles. Raise out_ready → consumed once, with no duplicate.
- Pointer wrap/skip: ptr=3, valid={ch1,ch0} → grant ch0, then ch1, then ch0.
- Fixed mode: MODE=MUX_FIXED, ch1 and ch3 held valid → ch1 granted every cycle and ch3 starves. Drop ch1 → ch3 granted next cycle.
- Reset mid-stall: out_valid=1 with data 8'h77, assert reset one cycle → out_valid=0, out_data=0, ptr=0. The held word is never observed by the consumer.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared arbitration mode and channel limits for the stream mux
package mux_pkg;

    typedef enum logic {
        MUX_RR    = 1'b0,
        MUX_FIXED = 1'b1
    } mux_mode_t;

    localparam int MUX_MAX_IN = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant over requests, round-robin pointer or fixed priority
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int        NUM_IN = 4,
    parameter mux_mode_t MODE   = MUX_RR,
    localparam int       IDX_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_start;
    logic [NUM_IN-1:0] w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_found;

    // Fixed priority is just a round-robin search that always starts at channel 0.
    assign w_start = (MODE == MUX_RR) ? r_ptr : '0;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            int c;
            c = int'(w_start) + k;
            if (c >= NUM_IN) begin
                c = c - NUM_IN;
            end
            if (!w_found && req[c]) begin
                w_found    = 1'b1;
                w_grant[c] = 1'b1;
                w_idx      = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (MODE == MUX_RR && advance) begin
            r_ptr <= (w_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign grant     = w_grant;
    assign grant_idx = w_idx;

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-input valid/ready stream selector with one registered output stage
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int        WIDTH  = 8,
    parameter int        NUM_IN = 4,
    parameter mux_mode_t MODE   = MUX_RR,
    localparam int       SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]  r_sel;
    logic              r_valid;

    logic [NUM_IN-1:0] w_grant;
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_accept;
    logic [NUM_IN-1:0] w_in_ready;
    logic              w_xfer;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .MODE   (MODE)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_valid),
        .advance   (w_xfer),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The slot can take a word when empty or when its current word leaves this cycle.
    assign w_accept   = ~r_valid | out_ready;
    assign w_in_ready = w_grant & {NUM_IN{w_accept & ~reset}};
    assign w_xfer     = |w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= in_data[w_grant_idx*WIDTH +: WIDTH];
            r_sel   <= w_grant_idx;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - vector table plus scoreboard for round-robin and fixed-priority muxes
module tb_stream_mux_rr;
    import mux_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  vld_rr, vld_fx, ir_rr, ir_fx;
    logic        ordy_rr, ordy_fx, ov_rr, ov_fx;
    logic [7:0]  od_rr, od_fx;
    logic [1:0]  os_rr, os_fx;

    stream_mux_rr #(.WIDTH(8), .NUM_IN(4), .MODE(MUX_RR)) dut_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vld_rr), .in_ready(ir_rr),
        .out_data(od_rr), .out_sel(os_rr), .out_valid(ov_rr), .out_ready(ordy_rr)
    );

    stream_mux_rr #(.WIDTH(8), .NUM_IN(4), .MODE(MUX_FIXED)) dut_fx (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vld_fx), .in_ready(ir_fx),
        .out_data(od_fx), .out_sel(os_fx), .out_valid(ov_fx), .out_ready(ordy_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fx;
        logic [3:0]  vld;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  e_ir;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_os;
    } vec_t;

    vec_t        tv[$];
    logic [9:0]  q_rr[$];
    logic [9:0]  q_fx[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur_row = 0;

    localparam logic [31:0] DA  = 32'hA3A2A1A0;
    localparam logic [31:0] D5C = 32'hA35CA1A0;
    localparam logic [31:0] D77 = 32'h77A2A1A0;

    function automatic vec_t mk(logic rst, logic fx, logic [3:0] vld, logic ordy, logic [31:0] data,
                                logic [3:0] e_ir, logic e_ov, logic [7:0] e_od, logic [1:0] e_os);
        vec_t v;
        v.rst = rst; v.fx = fx; v.vld = vld; v.ordy = ordy; v.data = data;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
        return v;
    endfunction

    function automatic int oh_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic sb_pop(logic fx, logic [1:0] sel, logic [7:0] data);
        logic [9:0] e;
        if (fx ? (q_fx.size() == 0) : (q_rr.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty step %0d: got word %h/%0d, expected none", cur_row, data, sel);
        end else begin
            e = fx ? q_fx.pop_front() : q_rr.pop_front();
            chk("sb_word", {22'd0, sel, data}, {22'd0, e});
        end
    endtask

    task automatic sb_push(logic fx, logic [9:0] w);
        if (fx) q_fx.push_back(w);
        else    q_rr.push_back(w);
    endtask

    logic [3:0] a_ir;
    logic       a_ov;
    logic [7:0] a_od;
    logic [1:0] a_os;
    logic [1:0] ptr_m;
    logic       ov_m, acc, found;
    int         gi, idx;
    logic [3:0] exp_ir;

    initial begin
        reset = 1'b1; in_data = DA;
        vld_rr = 4'h0; vld_fx = 4'h0; ordy_rr = 1'b1; ordy_fx = 1'b1;
        repeat (2) @(negedge clk);

        // round-robin: reset, fairness, backpressure, pointer skip, reset mid-stall
        tv.push_back(mk(1,0,4'hF,1,DA, 4'h0,0,8'h00,2'd0));
        tv.push_back(mk(0,0,4'hF,1,DA, 4'h1,0,8'h00,2'd0));
        tv.push_back(mk(0,0,4'hF,1,DA, 4'h2,1,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'hF,1,DA, 4'h4,1,8'hA1,2'd1));
        tv.push_back(mk(0,0,4'hF,1,DA, 4'h8,1,8'hA2,2'd2));
        tv.push_back(mk(0,0,4'hF,1,DA, 4'h1,1,8'hA3,2'd3));
        tv.push_back(mk(0,0,4'h0,1,DA, 4'h0,1,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'h4,0,D5C,4'h4,0,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'h4,0,D5C,4'h0,1,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h4,0,D5C,4'h0,1,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h4,0,D5C,4'h0,1,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h0,1,D5C,4'h0,1,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h0,1,D5C,4'h0,0,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h3,1,DA, 4'h1,0,8'h5C,2'd2));
        tv.push_back(mk(0,0,4'h3,1,DA, 4'h2,1,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'h3,1,DA, 4'h1,1,8'hA1,2'd1));
        tv.push_back(mk(0,0,4'h0,1,DA, 4'h0,1,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'h8,0,D77,4'h8,0,8'hA0,2'd0));
        tv.push_back(mk(0,0,4'h0,0,D77,4'h0,1,8'h77,2'd3));
        tv.push_back(mk(1,0,4'hF,0,D77,4'h0,1,8'h77,2'd3));
        tv.push_back(mk(0,0,4'hF,1,D77,4'h1,0,8'h00,2'd0));
        tv.push_back(mk(0,0,4'h0,1,D77,4'h0,1,8'hA0,2'd0));
        // fixed priority: ch1 starves ch3, then a stalled low-index grant
        tv.push_back(mk(0,1,4'hA,1,DA, 4'h2,0,8'h00,2'd0));
        tv.push_back(mk(0,1,4'hA,1,DA, 4'h2,1,8'hA1,2'd1));
        tv.push_back(mk(0,1,4'hA,1,DA, 4'h2,1,8'hA1,2'd1));
        tv.push_back(mk(0,1,4'h8,1,DA, 4'h8,1,8'hA1,2'd1));
        tv.push_back(mk(0,1,4'h0,1,DA, 4'h0,1,8'hA3,2'd3));
        tv.push_back(mk(0,1,4'h0,1,DA, 4'h0,0,8'hA3,2'd3));
        tv.push_back(mk(0,1,4'h3,0,DA, 4'h1,0,8'hA3,2'd3));
        tv.push_back(mk(0,1,4'h3,0,DA, 4'h0,1,8'hA0,2'd0));
        tv.push_back(mk(0,1,4'h0,1,DA, 4'h0,1,8'hA0,2'd0));

        for (int r = 0; r < tv.size(); r++) begin
            cur_row = r;
            @(negedge clk);
            reset   = tv[r].rst;
            in_data = tv[r].data;
            vld_rr  = tv[r].fx ? 4'h0 : tv[r].vld;
            ordy_rr = tv[r].fx ? 1'b1 : tv[r].ordy;
            vld_fx  = tv[r].fx ? tv[r].vld : 4'h0;
            ordy_fx = tv[r].fx ? tv[r].ordy : 1'b1;
            #1;
            a_ir = tv[r].fx ? ir_fx : ir_rr;
            a_ov = tv[r].fx ? ov_fx : ov_rr;
            a_od = tv[r].fx ? od_fx : od_rr;
            a_os = tv[r].fx ? os_fx : os_rr;
            chk("in_ready",  {28'd0, a_ir}, {28'd0, tv[r].e_ir});
            chk("out_valid", {31'd0, a_ov}, {31'd0, tv[r].e_ov});
            chk("out_data",  {24'd0, a_od}, {24'd0, tv[r].e_od});
            chk("out_sel",   {30'd0, a_os}, {30'd0, tv[r].e_os});
            if (tv[r].rst) begin
                q_rr.delete();
                q_fx.delete();
            end else begin
                if (a_ov && tv[r].ordy) sb_pop(tv[r].fx, a_os, a_od);
                if (tv[r].e_ir != 4'h0) begin
                    idx = oh_idx(tv[r].e_ir);
                    sb_push(tv[r].fx, {2'(idx), tv[r].data[idx*8 +: 8]});
                end
            end
        end

        // random traffic on the round-robin instance against a small reference model
        @(negedge clk);
        reset = 1'b1; vld_rr = 4'h0; vld_fx = 4'h0; ordy_rr = 1'b1; ordy_fx = 1'b1;
        q_rr.delete();
        ptr_m = 2'd0;
        ov_m  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            cur_row = 1000 + c;
            @(negedge clk);
            reset   = 1'b0;
            vld_rr  = 4'($urandom);
            ordy_rr = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            #1;
            acc   = !ov_m || ordy_rr;
            found = 1'b0;
            gi    = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && vld_rr[(int'(ptr_m) + k) % 4]) begin
                    found = 1'b1;
                    gi    = (int'(ptr_m) + k) % 4;
                end
            end
            exp_ir = (found && acc) ? (4'h1 << gi) : 4'h0;
            chk("rand_in_ready",  {28'd0, ir_rr}, {28'd0, exp_ir});
            chk("rand_out_valid", {31'd0, ov_rr}, {31'd0, ov_m});
            if (ov_m && ordy_rr) sb_pop(1'b0, os_rr, od_rr);
            if (exp_ir != 4'h0) begin
                sb_push(1'b0, {2'(gi), in_data[gi*8 +: 8]});
                ptr_m = 2'((gi + 1) % 4);
                ov_m  = 1'b1;
            end else if (ordy_rr) begin
                ov_m = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
